alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Multi-cycle execute stage sitting directly downstream of the ALU decoder. It consumes the 4-bit ALUControl code together with two operands and produces a result plus a Zero flag.
- Simple operations take one cycle. Shifts run iteratively, one bit per cycle, which avoids a full barrel shifter.
- Operand and result transfers use valid/ready handshakes on both sides, so the stage can be stalled by its consumer.

Parameters:
- WIDTH, 32, datapath width in bits. Must be a power of two ≥ 8. Shift amount width SW = $clog2(WIDTH), derived internally.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and ALUControl valid
- in_ready  output  1  stage can accept; high only in IDLE
- ALUControl  input  4  operation code from the ALU decoder
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B; shift amount is SrcB[SW-1:0]
- out_valid  output  1  ALUResult/Zero/Illegal valid
- out_ready  input  1  consumer accepts result
- ALUResult  output  WIDTH  registered result
- Zero  output  1  registered, ALUResult == 0
- Illegal  output  1  registered, ALUControl code was undefined

Behaviour:
- Reset (synchronous, any state): state=IDLE, out_valid=0, ALUResult=0, Zero=0, Illegal=0, shift counter=0. Reset mid-shift abandons the operation; no result is produced.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). Accept happens when in_valid & in_ready at a clock edge. Inputs are ignored in all other states.
- Encoding:
  - 0000 add
  - 0001 sub
  - 0010 sll
  - 0011 slt (signed)
  - 0100 sltu
  - 0101 xor
  - 0110 sra
  - 0111 srl
  - 1000 or
  - 1001 and
  - 1010–1111 undefined
- Add/sub wrap modulo 2^WIDTH; no overflow or carry output. slt/sltu produce {WIDTH-1 zeros, lt}.
- Non-shift accept (IDLE):
  - Compute combinationally and register ALUResult, Zero, Illegal=0.
  - Go to DONE, so out_valid is high the cycle after accept (latency 1).
- Undefined code: ALUResult=0, Zero=1, Illegal=1, go to DONE (latency 1).
- Shift accept, k = SrcB[SW-1:0]:
  - k==0: ALUResult=SrcA, go to DONE (latency 1).
  - k>0: load accumulator=SrcA, counter=k, latch shift kind, go to SHIFT.
- SHIFT, each cycle: shift the accumulator by one bit.
  - sll: shift left, fill 0.
  - srl: shift right, fill 0.
  - sra: shift right, fill with the MSB of the accumulator.
  - Decrement the counter. When the counter is 1 before the decrement, write the shifted value to ALUResult, set Zero, and go to DONE.
  - Total latency from accept to out_valid is k+1 cycles. Maximum is WIDTH cycles, for k = WIDTH-1.
- DONE: out_valid=1. ALUResult, Zero and Illegal are held stable while out_ready=0.
  - When out_ready=1 at an edge, go to IDLE and drop out_valid.
  - No new accept happens in the same cycle, so the minimum issue interval is 2 cycles.
- Zero and Illegal are meaningful only while out_valid=1. Their values outside DONE are don't-care, except at reset.
- Operand changes after accept have no effect; all operands are captured at accept.

Test Plan:
- Reset, then add SrcA=0x00000005, SrcB=0x00000003, out_ready=1 → out_valid exactly 1 cycle after accept, ALUResult=0x00000008, Zero=0, then in_ready returns high.
- sub 0x12345678 − 0x12345678 → ALUResult=0, Zero=1. slt 0xFFFFFFFF vs 1 → ALUResult=1; sltu with the same operands → ALUResult=0.
- sra SrcA=0x80000000, SrcB=0x00000004 → out_valid 5 cycles after accept, ALUResult=0xF8000000. Same operands with srl → 0x08000000. sll of 0x1 by 31 → 0x80000000 after 32 cycles.
- Shift by 0 (SrcB=0x20, low 5 bits=0) → latency 1, ALUResult=SrcA. ALUControl=1100 → ALUResult=0, Zero=1, Illegal=1.
- Backpressure: hold out_ready=0 for 6 cycles after an xor result → out_valid and ALUResult stay stable and in_ready=0 throughout. Raise out_ready → IDLE next cycle. in_valid pulses during DONE are not accepted.
- Assert reset during SHIFT (sll by 20, reset at cycle 8) → next cycle out_valid=0, in_ready=1, ALUResult=0. A following and 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0.

Source files
------------

// File: rtl/alu_seq_exec.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_seq_exec                                                 |
// | Description : Multi-cycle ALU execute stage with valid/ready handshakes;   |
// |               shifts run one bit per cycle.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_sll  = 4'b0010;
    localparam logic [3:0] c_op_slt  = 4'b0011;
    localparam logic [3:0] c_op_sltu = 4'b0100;
    localparam logic [3:0] c_op_xor  = 4'b0101;
    localparam logic [3:0] c_op_sra  = 4'b0110;
    localparam logic [3:0] c_op_srl  = 4'b0111;
    localparam logic [3:0] c_op_or   = 4'b1000;
    localparam logic [3:0] c_op_and  = 4'b1001;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [SW-1:0] c_cnt_one = {{(SW-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [SW-1:0]    r_cnt;
    logic [3:0]       r_kind;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic [SW-1:0]    w_k;
    logic             w_is_shift;
    logic             w_illegal;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_shifted;

    assign w_k        = SrcB[SW-1:0];
    assign w_is_shift = (ALUControl == c_op_sll) || (ALUControl == c_op_srl) ||
                        (ALUControl == c_op_sra);
    assign w_illegal  = (ALUControl > c_op_and);

    // Shift codes yield SrcA here, which is exactly the k==0 result.
    always_comb begin
        w_alu = '0;
        case (ALUControl)
            c_op_add:  w_alu = SrcA + SrcB;
            c_op_sub:  w_alu = SrcA - SrcB;
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            c_op_xor:  w_alu = SrcA ^ SrcB;
            c_op_or:   w_alu = SrcA | SrcB;
            c_op_and:  w_alu = SrcA & SrcB;
            c_op_sll,
            c_op_srl,
            c_op_sra:  w_alu = SrcA;
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        w_shifted = r_acc;
        case (r_kind)
            c_op_sll: w_shifted = {r_acc[WIDTH-2:0], 1'b0};
            c_op_srl: w_shifted = {1'b0, r_acc[WIDTH-1:1]};
            c_op_sra: w_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default:  w_shifted = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_kind      <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        if (w_is_shift && (w_k != '0)) begin
                            r_acc   <= SrcA;
                            r_cnt   <= w_k;
                            r_kind  <= ALUControl;
                            r_state <= c_st_shift;
                        end else begin
                            r_result    <= w_alu;
                            r_zero      <= (w_alu == '0);
                            r_illegal   <= w_illegal;
                            r_out_valid <= 1'b1;
                            r_state     <= c_st_done;
                        end
                    end
                end
                c_st_shift: begin
                    r_acc <= w_shifted;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_result    <= w_shifted;
                        r_zero      <= (w_shifted == '0);
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = r_out_valid;
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign Illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_seq_exec                                              |
// | Description : Self-checking bench for alu_seq_exec against a reference     |
// |               model of the operation set.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result, illegal flag and accept-to-valid latency.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output int lat);
        int k;
        k   = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << k;
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = $signed(a) >>> k;
            4'd7: r = a >> k;
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && k > 0) lat = k + 1;
    endfunction

    // Issues one operation with out_ready high; returns observed values.
    // lat is -1 if out_valid never rose within the cycle budget.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output logic ill,
                         output int lat);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ALUControl = 4'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = ALUResult;
        z   = Zero;
        ill = Illegal;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0 ||
            Zero !== 1'b0 || Illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ov=%b ir=%b res=%h z=%b ill=%b, want ov=0 ir=1 res=0 z=0 ill=0",
                     out_valid, in_ready, ALUResult, Zero, Illegal);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0]  ops [8]  = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd2, 4'd2};
        logic [31:0] as  [8]  = '{32'h5, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h80000000, 32'h1, 32'hDEADBEEF};
        logic [31:0] bs  [8]  = '{32'h3, 32'h12345678, 32'h1, 32'h1,
                                  32'h4, 32'h4, 32'd31, 32'h20};
        logic [31:0] exp [8]  = '{32'h8, 32'h0, 32'h1, 32'h0,
                                  32'hF8000000, 32'h08000000, 32'h80000000, 32'hDEADBEEF};
        int          elat [8] = '{1, 1, 1, 1, 5, 5, 32, 1};
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], res, z, ill, lat);
            n_tests++;
            if (res !== exp[i] || z !== (exp[i] == 32'd0) || ill !== 1'b0 || lat != elat[i]) begin
                n_fail++;
                $display("FAIL directed[%0d]: res=%h z=%b ill=%b lat=%0d, want res=%h z=%b ill=0 lat=%0d",
                         i, res, z, ill, lat, exp[i], (exp[i] == 32'd0), elat[i]);
            end
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_idle[%0d]: ir=%b ov=%b, want ir=1 ov=0", i, in_ready, out_valid);
            end
        end
        do_op(4'b1100, 32'h12345678, 32'h9, res, z, ill, lat);
        n_tests++;
        if (res !== 32'd0 || z !== 1'b1 || ill !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL illegal: res=%h z=%b ill=%b lat=%0d, want res=0 z=1 ill=1 lat=1",
                     res, z, ill, lat);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, res, er;
        logic        z, ill, eill;
        int          lat, elat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = (i % 5 == 0) ? 32'h0 : $urandom;
            b  = (i % 7 == 0) ? a : $urandom;
            model(op, a, b, er, eill, elat);
            do_op(op, a, b, res, z, ill, lat);
            n_tests++;
            if (res !== er || z !== (er == 32'd0) || ill !== eill || lat != elat) begin
                n_fail++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: res=%h z=%b ill=%b lat=%0d, want res=%h z=%b ill=%b lat=%0d",
                         i, op, a, b, res, z, ill, lat, er, (er == 32'd0), eill, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] er;
        er = 32'hA5A5F00F ^ 32'h0F0F1234;
        in_valid   = 1'b1;
        ALUControl = 4'd5;
        SrcA       = 32'hA5A5F00F;
        SrcB       = 32'h0F0F1234;
        out_ready  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || ALUResult !== er || in_ready !== 1'b0 || Zero !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: ov=%b res=%h ir=%b z=%b, want ov=1 res=%h ir=0 z=0",
                         c, out_valid, ALUResult, in_ready, Zero, er);
            end
            in_valid   = c[0];
            ALUControl = 4'd0;
            SrcA       = $urandom;
            SrcB       = $urandom;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_accept: ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] res;
        logic        z, ill;
        int          lat;
        in_valid   = 1'b1;
        ALUControl = 4'd2;
        SrcA       = 32'h00000ABC;
        SrcB       = 32'd20;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: ov=%b ir=%b res=%h, want ov=0 ir=1 res=0",
                     out_valid, in_ready, ALUResult);
        end
        repeat (15) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abandoned_shift: ov=%b, want 0", out_valid);
            end
        end
        do_op(4'd9, 32'hF0F0F0F0, 32'h0FF00FF0, res, z, ill, lat);
        n_tests++;
        if (res !== 32'h00F000F0 || z !== 1'b0 || ill !== 1'b0 || lat != 1) begin
            n_fail++;
            $display("FAIL and_after_reset: res=%h z=%b ill=%b lat=%0d, want res=00f000f0 z=0 ill=0 lat=1",
                     res, z, ill, lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        ALUControl = 4'd0;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        out_ready  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
